// File: rtl/regfile_2r1w.sv
// Architectural RV32I integer register file: x1..x31 stored, x0 hard-wired to zero, two operand read ports plus a debug read port.
// Latency: reads are combinational (zero cycles); a write lands on the rising edge and is visible on stored reads right after it.
// Backpressure: none; every write presented with i_rd_wren set completes at the next rising edge of i_clk.
module regfile_2r1w #(
  parameter int unsigned XLEN   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_rd_wren,
  input  logic [4:0]      i_rd_addr,
  input  logic [XLEN-1:0] i_rd_data,
  input  logic [4:0]      i_dbg_addr,
  output logic [XLEN-1:0] o_dbg_data
);

  // Only x1..x31 are physical; x0 never gets a flop.
  logic [XLEN-1:0] regs [1:31];

  // Address-indexed view of the file with x0 supplied as a constant zero,
  // so every read port is a plain 32:1 mux with no special case for x0.
  logic [XLEN-1:0] rd_view [0:31];

  // Writes to x0 are dropped here rather than at the array.
  logic wr_hit;
  assign wr_hit = i_rd_wren && (i_rd_addr != 5'd0);

  // Forwarding is decided per port; address 0 is excluded so x0 always reads 0
  // even when a write to x0 is presented in the same cycle.
  logic byp_rs1;
  logic byp_rs2;
  assign byp_rs1 = BYPASS && i_rd_wren && (i_rs1_addr != 5'd0) && (i_rd_addr == i_rs1_addr);
  assign byp_rs2 = BYPASS && i_rd_wren && (i_rs2_addr != 5'd0) && (i_rd_addr == i_rs2_addr);

  // Register storage: asynchronous clear, one write per edge, never while reset is high.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[i_rd_addr] <= i_rd_data;
    end
  end

  // Build the read view with x0 tied to zero.
  always_comb begin
    rd_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      rd_view[i] = regs[i];
    end
  end

  // Operand ports: the bypass is the last 2:1 level on the rs1/rs2 path.
  always_comb begin
    o_rs1_data = byp_rs1 ? i_rd_data : rd_view[i_rs1_addr];
    o_rs2_data = byp_rs2 ? i_rd_data : rd_view[i_rs2_addr];
  end

  // Debug port always shows the stored architectural state, never forwarded data.
  always_comb begin
    o_dbg_data = rd_view[i_dbg_addr];
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  dbg_addr;

  logic [31:0] rs1_b, rs2_b, dbg_b;
  logic [31:0] rs1_n, rs2_n, dbg_n;

  regfile_2r1w #(.XLEN(32), .BYPASS(1'b1)) u_byp (
    .i_clk(clk), .i_reset(rst),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_data(rs1_b), .o_rs2_data(rs2_b),
    .i_rd_wren(wren), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_b)
  );

  regfile_2r1w #(.XLEN(32), .BYPASS(1'b0)) u_nob (
    .i_clk(clk), .i_reset(rst),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_rs1_data(rs1_n), .o_rs2_data(rs2_n),
    .i_rd_wren(wren), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state of x0..x31 (x0 entry stays zero).
  logic [31:0] mdl [0:31];
  logic [31:0] exp_q [$];
  int n_cmp;
  int n_fail;

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && wren && (rd_addr == a)) return rd_data;
    return mdl[a];
  endfunction

  // Push the six expected outputs (bypass instance then non-bypass instance).
  task automatic push_expected();
    exp_q.push_back(exp_rd(rs1_addr, 1'b1));
    exp_q.push_back(exp_rd(rs2_addr, 1'b1));
    exp_q.push_back(exp_rd(dbg_addr, 1'b0));
    exp_q.push_back(exp_rd(rs1_addr, 1'b0));
    exp_q.push_back(exp_rd(rs2_addr, 1'b0));
    exp_q.push_back(exp_rd(dbg_addr, 1'b0));
  endtask

  function automatic logic [31:0] obs(input int j);
    case (j)
      0: return rs1_b;
      1: return rs2_b;
      2: return dbg_b;
      3: return rs1_n;
      4: return rs2_n;
      default: return dbg_n;
    endcase
  endfunction

  function automatic string pname(input int j);
    case (j)
      0: return "byp.rs1";
      1: return "byp.rs2";
      2: return "byp.dbg";
      3: return "nob.rs1";
      4: return "nob.rs2";
      default: return "nob.dbg";
    endcase
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endfunction

  // One rising edge; the model takes the write the DUT should take on it.
  task automatic tick();
    bit          do_wr;
    logic [4:0]  a;
    logic [31:0] d;
    do_wr = wren && (rd_addr != 5'd0) && !rst;
    a = rd_addr;
    d = rd_data;
    @(posedge clk);
    if (do_wr) mdl[a] = d;
    #1;
  endtask

  task automatic set_rd(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dg);
    rs1_addr = r1;
    rs2_addr = r2;
    dbg_addr = dg;
  endtask

  task automatic test_reset();
    logic [31:0] e, o;
    clear_model();
    for (int k = 0; k < 3; k++) begin
      set_rd(5'(k * 13 + 5), 5'(31 - k), 5'(k * 7 + 1));
      #1;
      push_expected();
      for (int j = 0; j < 6; j++) begin
        e = exp_q.pop_front(); o = obs(j); n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL reset_state %s: got %h expected %h", pname(j), o, e); end
      end
    end
    tick();
    rst = 1'b0;
    // Store a value in x5, then clear it asynchronously mid-cycle.
    wren = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
    tick();
    wren = 1'b0;
    set_rd(5'd5, 5'd5, 5'd5);
    #1;
    push_expected();
    for (int j = 0; j < 6; j++) begin
      e = exp_q.pop_front(); o = obs(j); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL x5_written %s: got %h expected %h", pname(j), o, e); end
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    clear_model();
    #1;
    push_expected();
    for (int j = 0; j < 6; j++) begin
      e = exp_q.pop_front(); o = obs(j); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL async_clear %s: got %h expected %h", pname(j), o, e); end
    end
    tick();
    rst = 1'b0;
    #1;
    push_expected();
    for (int j = 0; j < 6; j++) begin
      e = exp_q.pop_front(); o = obs(j); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL after_release %s: got %h expected %h", pname(j), o, e); end
    end
  endtask

  task automatic test_x0();
    logic [31:0] e, o;
    wren = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF;
    set_rd(5'd0, 5'd0, 5'd0);
    #1;
    push_expected();
    for (int j = 0; j < 6; j++) begin
      e = exp_q.pop_front(); o = obs(j); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL x0_same_cycle %s: got %h expected %h", pname(j), o, e); end
    end
    tick();
    wren = 1'b0;
    #1;
    push_expected();
    for (int j = 0; j < 6; j++) begin
      e = exp_q.pop_front(); o = obs(j); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL x0_after %s: got %h expected %h", pname(j), o, e); end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] e, o;
    for (int k = 1; k < 32; k++) begin
      wren = 1'b1; rd_addr = 5'(k); rd_data = 32'h1000_0000 + 32'(k);
      tick();
    end
    wren = 1'b0;
    for (int k = 1; k < 32; k++) begin
      set_rd(5'(k), 5'(32 - k), 5'(k));
      #1;
      push_expected();
      for (int j = 0; j < 6; j++) begin
        e = exp_q.pop_front(); o = obs(j); n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL sweep k=%0d %s: got %h expected %h", k, pname(j), o, e); end
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] e, o;
    wren = 1'b1; rd_addr = 5'd7; rd_data = 32'h11;
    tick();
    rd_data = 32'h22;
    set_rd(5'd7, 5'd7, 5'd7);
    #1;
    push_expected();
    for (int j = 0; j < 6; j++) begin
      e = exp_q.pop_front(); o = obs(j); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL bypass_before %s: got %h expected %h", pname(j), o, e); end
    end
    tick();
    wren = 1'b0;
    #1;
    push_expected();
    for (int j = 0; j < 6; j++) begin
      e = exp_q.pop_front(); o = obs(j); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL bypass_after %s: got %h expected %h", pname(j), o, e); end
    end
  endtask

  task automatic test_reset_collision();
    logic [31:0] e, o;
    @(negedge clk);
    #1;
    rst = 1'b1;
    clear_model();
    wren = 1'b1; rd_addr = 5'd3; rd_data = 32'hA5A5A5A5;
    set_rd(5'd3, 5'd3, 5'd3);
    #1;
    push_expected();
    for (int j = 0; j < 6; j++) begin
      e = exp_q.pop_front(); o = obs(j); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL coll_in_reset %s: got %h expected %h", pname(j), o, e); end
    end
    // Reset is still high on this edge and drops just after it.
    tick();
    rst = 1'b0;
    wren = 1'b0;
    #1;
    push_expected();
    for (int j = 0; j < 6; j++) begin
      e = exp_q.pop_front(); o = obs(j); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL coll_dropped %s: got %h expected %h", pname(j), o, e); end
    end
    wren = 1'b1; rd_data = 32'h5A5A5A5A;
    tick();
    wren = 1'b0;
    #1;
    push_expected();
    for (int j = 0; j < 6; j++) begin
      e = exp_q.pop_front(); o = obs(j); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL coll_next_write %s: got %h expected %h", pname(j), o, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, o;
    for (int c = 0; c < 200; c++) begin
      wren    = 1'($urandom_range(0, 1));
      rd_addr = 5'($urandom_range(0, 31));
      rd_data = $urandom;
      rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      dbg_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      #1;
      push_expected();
      for (int j = 0; j < 6; j++) begin
        e = exp_q.pop_front(); o = obs(j); n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL b2b c=%0d %s: got %h expected %h", c, pname(j), o, e); end
      end
      tick();
    end
    wren = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    wren = 1'b0;
    rd_addr = 5'd0;
    rd_data = 32'h0;
    set_rd(5'd0, 5'd0, 5'd0);
    test_reset();
    test_x0();
    test_sweep();
    test_bypass();
    test_reset_collision();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
